// File: rtl/cmp_stream_tracker_pkg.sv
// Shared definitions for the stream tracker: FSM state encoding and datapath widths.
package cmp_stream_tracker_pkg;

    localparam int WIDTH = 4;
    localparam int LEN_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/cmp_stream_tracker_comparator.sv
// 4-bit magnitude comparator with scalar operand bits; exactly one of g/e/l is high.
module comparator (
    input  logic A3,
    input  logic A2,
    input  logic A1,
    input  logic A0,
    input  logic B3,
    input  logic B2,
    input  logic B1,
    input  logic B0,
    output logic g,
    output logic e,
    output logic l
);

    logic x3, x2, x1, x0;

    // Per-bit equality feeds the MSB-first priority cascade for g.
    assign x3 = ~(A3 ^ B3);
    assign x2 = ~(A2 ^ B2);
    assign x1 = ~(A1 ^ B1);
    assign x0 = ~(A0 ^ B0);

    assign e = x3 & x2 & x1 & x0;
    assign g = (A3 & ~B3)
             | (x3 & A2 & ~B2)
             | (x3 & x2 & A1 & ~B1)
             | (x3 & x2 & x1 & A0 & ~B0);
    assign l = ~g & ~e;

endmodule

// File: rtl/cmp_stream_tracker.sv
// Windowed stream tracker: running max/min plus up/equal step counts, driven by three
// magnitude comparators against max, min and the previous sample.
module cmp_stream_tracker #(
    parameter int WIDTH = cmp_stream_tracker_pkg::WIDTH,
    parameter int LEN_W = cmp_stream_tracker_pkg::LEN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] max_out,
    output logic [WIDTH-1:0] min_out,
    output logic [LEN_W-1:0] up_cnt,
    output logic [LEN_W-1:0] eq_cnt,
    output logic             busy,
    output logic             done
);

    import cmp_stream_tracker_pkg::*;

    state_e           state_q;
    logic [LEN_W-1:0] rem_q;
    logic             first_q;
    logic             done_q;
    logic [WIDTH-1:0] max_q, max_d;
    logic [WIDTH-1:0] min_q, min_d;
    logic [WIDTH-1:0] prev_q;
    logic [LEN_W-1:0] up_q, up_d;
    logic [LEN_W-1:0] eq_q, eq_d;
    logic             accept;

    logic a_g, a_e, a_l;
    logic b_g, b_e, b_l;
    logic c_g, c_e, c_l;
    logic unused_flags;

    comparator u_cmp_a (
        .A3(in_data[3]), .A2(in_data[2]), .A1(in_data[1]), .A0(in_data[0]),
        .B3(max_q[3]),   .B2(max_q[2]),   .B1(max_q[1]),   .B0(max_q[0]),
        .g(a_g), .e(a_e), .l(a_l)
    );

    comparator u_cmp_b (
        .A3(in_data[3]), .A2(in_data[2]), .A1(in_data[1]), .A0(in_data[0]),
        .B3(min_q[3]),   .B2(min_q[2]),   .B1(min_q[1]),   .B0(min_q[0]),
        .g(b_g), .e(b_e), .l(b_l)
    );

    comparator u_cmp_c (
        .A3(in_data[3]), .A2(in_data[2]), .A1(in_data[1]), .A0(in_data[0]),
        .B3(prev_q[3]),  .B2(prev_q[2]),  .B1(prev_q[1]),  .B0(prev_q[0]),
        .g(c_g), .e(c_e), .l(c_l)
    );

    // Ties with max/min and downward steps need no action.
    assign unused_flags = ^{a_e, a_l, b_g, b_e, c_l};

    assign accept = in_valid && (state_q == RUN);

    always_comb begin
        max_d = max_q;
        min_d = min_q;
        up_d  = up_q;
        eq_d  = eq_q;
        if (first_q) begin
            max_d = in_data;
            min_d = in_data;
        end else begin
            if (a_g) max_d = in_data;
            if (b_l) min_d = in_data;
            if (c_g) up_d  = up_q + 1'b1;
            if (c_e) eq_d  = eq_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            first_q <= 1'b0;
            done_q  <= 1'b0;
            max_q   <= '0;
            min_q   <= '0;
            prev_q  <= '0;
            up_q    <= '0;
            eq_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        max_q  <= '0;
                        min_q  <= '0;
                        prev_q <= '0;
                        up_q   <= '0;
                        eq_q   <= '0;
                        if (len != '0) begin
                            state_q <= RUN;
                            rem_q   <= len;
                            first_q <= 1'b1;
                        end else begin
                            // Empty window completes immediately with cleared results.
                            state_q <= DONE;
                            rem_q   <= '0;
                            first_q <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        max_q   <= max_d;
                        min_q   <= min_d;
                        up_q    <= up_d;
                        eq_q    <= eq_d;
                        prev_q  <= in_data;
                        first_q <= 1'b0;
                        rem_q   <= rem_q - 1'b1;
                        if (rem_q == LEN_W'(1)) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready = (state_q == RUN);
    assign busy     = (state_q == RUN);
    assign done     = done_q;
    assign max_out  = max_q;
    assign min_out  = min_q;
    assign up_cnt   = up_q;
    assign eq_cnt   = eq_q;

endmodule

// File: tb/tb_cmp_stream_tracker.sv
// Directed bench with a result scoreboard: windows push expected results, a monitor pops on done.
module tb_cmp_stream_tracker;

    typedef struct packed {
        logic [3:0] mx;
        logic [3:0] mn;
        logic [3:0] up;
        logic [3:0] eq;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] len;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic [3:0] max_out;
    logic [3:0] min_out;
    logic [3:0] up_cnt;
    logic [3:0] eq_cnt;
    logic       busy;
    logic       done;

    exp_t exp_q[$];
    exp_t cur;
    int   vectors     = 0;
    int   miscompares = 0;
    int   done_seen   = 0;
    int   pushed      = 0;
    logic done_prev   = 1'b0;

    cmp_stream_tracker dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .max_out(max_out), .min_out(min_out), .up_cnt(up_cnt), .eq_cnt(eq_cnt),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic expect_win(input logic [3:0] mx, input logic [3:0] mn,
                              input logic [3:0] up, input logic [3:0] eq);
        exp_t e;
        e.mx = mx; e.mn = mn; e.up = up; e.eq = eq;
        exp_q.push_back(e);
        pushed++;
    endtask

    task automatic do_start(input logic [3:0] l);
        @(negedge clk);
        start = 1'b1;
        len   = l;
        @(negedge clk);
        start = 1'b0;
        len   = 4'd0;
    endtask

    task automatic send(input logic [3:0] d);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: in_ready=%0b, expected 1 for sample %0d", in_ready, d);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_max"},   max_out,  0);
        chk({tag, "_min"},   min_out,  0);
        chk({tag, "_up"},    up_cnt,   0);
        chk({tag, "_eq"},    eq_cnt,   0);
        chk({tag, "_busy"},  busy,     0);
        chk({tag, "_ready"}, in_ready, 0);
        chk({tag, "_done"},  done,     0);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (done === 1'b1) begin
                done_seen++;
                chk("done_width", done_prev, 0);
                chk("done_ready", in_ready, 0);
                chk("done_busy", busy, 0);
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_done: got done=1, expected no window pending");
                end else begin
                    cur = exp_q.pop_front();
                    chk("max_out", max_out, cur.mx);
                    chk("min_out", min_out, cur.mn);
                    chk("up_cnt",  up_cnt,  cur.up);
                    chk("eq_cnt",  eq_cnt,  cur.eq);
                end
            end
            done_prev = done;
        end else begin
            done_prev = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        len      = 4'd0;
        in_valid = 1'b0;
        in_data  = 4'd0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;

        // Reset in the middle of a window: no result, no done.
        do_start(4'd4);
        chk("run_busy", busy, 1);
        send(4'd5);
        send(4'd9);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_zero("postreset");
        expect_win(4'd3, 4'd3, 4'd0, 4'd0);
        do_start(4'd1);
        send(4'd3);

        // Basic window.
        expect_win(4'd9, 4'd2, 4'd2, 4'd1);
        do_start(4'd5);
        send(4'd3);
        send(4'd7);
        send(4'd7);
        send(4'd2);
        send(4'd9);
        chk("basic_done_now", done, 1);
        chk("basic_ready_now", in_ready, 0);
        @(negedge clk);
        chk("basic_ready_after", in_ready, 0);
        chk("basic_done_after", done, 0);
        chk("basic_max_hold", max_out, 9);

        // Zero-length window clears the previous results.
        expect_win(4'd0, 4'd0, 4'd0, 4'd0);
        @(negedge clk);
        start = 1'b1;
        len   = 4'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = 1'b0;
            chk("len0_ready", in_ready, 0);
        end

        // Stalls between samples.
        expect_win(4'd4, 4'd4, 4'd0, 4'd2);
        do_start(4'd3);
        for (int s = 0; s < 3; s++) begin
            send(4'd4);
            if (s < 2) begin
                for (int k = 0; k < 2; k++) begin
                    @(negedge clk);
                    chk("stall_busy", busy, 1);
                end
            end
        end

        // Back-to-back windows with start issued in the DONE cycle.
        expect_win(4'd15, 4'd0, 4'd0, 4'd0);
        expect_win(4'd8, 4'd8, 4'd0, 4'd1);
        do_start(4'd2);
        send(4'd15);
        send(4'd0);
        chk("b2b_done", done, 1);
        start = 1'b1;
        len   = 4'd2;
        @(negedge clk);
        start = 1'b0;
        len   = 4'd0;
        chk("b2b_busy", busy, 1);
        send(4'd8);
        send(4'd8);

        // start is ignored while a window runs.
        expect_win(4'd6, 4'd1, 4'd1, 4'd1);
        do_start(4'd3);
        send(4'd1);
        @(negedge clk);
        start = 1'b1;
        len   = 4'd1;
        @(negedge clk);
        start = 1'b0;
        len   = 4'd0;
        chk("ign_busy", busy, 1);
        send(4'd6);
        chk("ign_busy_mid", busy, 1);
        send(4'd6);

        repeat (4) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        chk("done_count", done_seen, pushed);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
